iter_decoder_core: RTL and testbench

Iterative min-sum decoder controller. It wraps one externally instantiated per-iteration message layer (variable-node plus check-node pass) and runs it repeatedly with registered edge messages. After each iteration it forms hard decisions and checks the syndrome, and it stops early on a valid codeword or at `MAX_ITER`. It sits between the channel-LLR source and the downstream bit consumer, and generalises the single-iteration layer to parametrised message width, layer latency and iteration count.

---
 rtl/iter_decoder_core.sv | 126 ++++++++++++
 tb/tb_iter_decoder_core.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_decoder_core.sv
// Iterative min-sum decoder controller: drives an external message layer,
// forms hard decisions after every pass and stops on a zero syndrome or MAX_ITER.
module iter_decoder_core #(
  parameter int N_V       = 44,
  parameter int N_C       = 12,
  parameter int E         = 147,
  parameter int W         = 8,
  parameter int MAX_ITER  = 10,
  parameter int LAYER_LAT = 1,
  parameter int ITER_W    = $clog2(MAX_ITER + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          tanner_g [0:E-1][0:1],
  input  logic signed [W-1:0] llr      [0:N_V-1],
  input  logic                start,
  output logic signed [W-1:0] llr_q    [0:N_V-1],
  output logic signed [W-1:0] msg_out  [0:E-1],
  input  logic signed [W-1:0] msg_in   [0:E-1],
  output logic                busy,
  output logic                done,
  output logic                success,
  output logic [ITER_W-1:0]   iter_used,
  output logic [N_V-1:0]      hard_bits
);

  localparam int LAT_W = (LAYER_LAT > 0) ? $clog2(LAYER_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK
  } state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic signed [15:0] post      [0:N_V-1];
  logic [N_V-1:0]     decisions;
  logic [255:0]       hb_ext;
  logic [255:0]       syn_ext;
  logic               syn_zero;

  // Posterior per variable: channel LLR plus every incoming edge message,
  // sign-extended to 16 bits so no degree <= 255 can overflow.
  always_comb begin
    decisions = '0;
    for (int unsigned v = 0; v < N_V; v++) begin
      post[v] = {{(16-W){llr_q[v][W-1]}}, llr_q[v]};
      for (int unsigned e = 0; e < E; e++) begin
        if (tanner_g[e][0] == 8'(v))
          post[v] = post[v] + {{(16-W){msg_in[e][W-1]}}, msg_in[e]};
      end
      decisions[v] = (post[v] < 16'sd0);
    end
  end

  // hard_bits is zero-extended to the full 8-bit index space, so out-of-range
  // variable indices contribute nothing and out-of-range checks are skipped.
  always_comb begin
    hb_ext = '0;
    hb_ext[N_V-1:0] = hard_bits;
    syn_ext = '0;
    for (int unsigned e = 0; e < E; e++) begin
      if (tanner_g[e][1] < 8'(N_C))
        syn_ext[tanner_g[e][1]] = syn_ext[tanner_g[e][1]] ^ hb_ext[tanner_g[e][0]];
    end
    syn_zero = (syn_ext == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      success   <= 1'b0;
      iter_used <= '0;
      hard_bits <= '0;
      lat_cnt   <= '0;
      for (int unsigned v = 0; v < N_V; v++) llr_q[v] <= '0;
      for (int unsigned e = 0; e < E; e++) msg_out[e] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned v = 0; v < N_V; v++) llr_q[v] <= llr[v];
            for (int unsigned e = 0; e < E; e++) msg_out[e] <= '0;
            iter_used <= '0;
            success   <= 1'b0;
            lat_cnt   <= '0;
            busy      <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == LAT_W'(LAYER_LAT)) begin
            for (int unsigned e = 0; e < E; e++) msg_out[e] <= msg_in[e];
            hard_bits <= decisions;
            iter_used <= iter_used + ITER_W'(1);
            state     <= S_CHECK;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        S_CHECK: begin
          if (syn_zero) begin
            success <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (iter_used == ITER_W'(MAX_ITER)) begin
            success <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            lat_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_decoder_core.sv
// Bench for iter_decoder_core on a Hamming(7,4) Tanner graph with two out-of-range
// edges; one DUT with a registered layer (LAYER_LAT=1), one with a combinational layer.
module tb_iter_decoder_core;

  localparam int N_V  = 7;
  localparam int N_C  = 3;
  localparam int E    = 14;
  localparam int W    = 8;
  localparam int MAX1 = 10;
  localparam int MAX0 = 4;
  localparam int IW1  = $clog2(MAX1 + 1);
  localparam int IW0  = $clog2(MAX0 + 1);

  localparam int M_CONST  = 0;
  localparam int M_FORCE  = 1;
  localparam int M_ONCE   = 2;
  localparam int M_MINSUM = 3;

  typedef logic signed [W-1:0] llr_t [0:N_V-1];
  typedef logic signed [W-1:0] msg_t [0:E-1];
  typedef logic [7:0]          tg_t  [0:E-1][0:1];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst0, start1, start0;
  tg_t  tg;
  llr_t llr;
  int   mode;

  llr_t llr_q1, llr_q0;
  msg_t msg_out1, msg_out0, msg_in1, msg_in0;
  logic busy1, busy0, done1, done0, succ1, succ0;
  logic [IW1-1:0] iter1;
  logic [IW0-1:0] iter0;
  logic [N_V-1:0] hard1, hard0;

  int checks = 0;
  int errors = 0;

  logic           o_busy, o_done, o_succ;
  int             o_iter;
  logic [N_V-1:0] o_hard;
  llr_t           o_llrq;
  msg_t           o_mo;

  iter_decoder_core #(.N_V(N_V), .N_C(N_C), .E(E), .W(W), .MAX_ITER(MAX1), .LAYER_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .tanner_g(tg), .llr(llr), .start(start1), .llr_q(llr_q1),
    .msg_out(msg_out1), .msg_in(msg_in1), .busy(busy1), .done(done1), .success(succ1),
    .iter_used(iter1), .hard_bits(hard1));

  iter_decoder_core #(.N_V(N_V), .N_C(N_C), .E(E), .W(W), .MAX_ITER(MAX0), .LAYER_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst0), .tanner_g(tg), .llr(llr), .start(start0), .llr_q(llr_q0),
    .msg_out(msg_out0), .msg_in(msg_in0), .busy(busy0), .done(done0), .success(succ0),
    .iter_used(iter0), .hard_bits(hard0));

  function automatic int var_llr(input llr_t lq, input logic [7:0] idx);
    int r = 0;
    for (int v = 0; v < N_V; v++) if (idx == 8'(v)) r = int'(lq[v]);
    return r;
  endfunction

  // Stub / behavioural layer: the message set the layer hands back for one pass.
  function automatic msg_t layer_f(input int md, input tg_t g, input llr_t lq, input msg_t mo);
    msg_t r;
    int   vc [0:E-1];
    bit   allz;
    int   sgn, mn, mag;
    allz = 1;
    for (int e = 0; e < E; e++) begin
      r[e] = '0;
      vc[e] = 0;
      if (mo[e] != 0) allz = 0;
    end
    if (md == M_CONST || (md == M_ONCE && !allz)) begin
      for (int e = 0; e < E; e++) r[e] = 8'sd5;
    end else if (md == M_FORCE || md == M_ONCE) begin
      r[12] = -8'sd100;
      r[13] = -8'sd100;
    end else begin
      for (int e = 0; e < E; e++) begin
        if (g[e][0] < 8'(N_V) && g[e][1] < 8'(N_C)) begin
          vc[e] = var_llr(lq, g[e][0]);
          for (int e2 = 0; e2 < E; e2++)
            if (e2 != e && g[e2][0] == g[e][0] && g[e2][1] < 8'(N_C)) vc[e] += int'(mo[e2]);
        end
      end
      for (int e = 0; e < E; e++) begin
        if (g[e][1] < 8'(N_C)) begin
          sgn = 1;
          mn  = 1000;
          for (int e2 = 0; e2 < E; e2++) begin
            if (e2 != e && g[e2][1] == g[e][1]) begin
              if (vc[e2] < 0) sgn = -sgn;
              mag = (vc[e2] < 0) ? -vc[e2] : vc[e2];
              if (mag < mn) mn = mag;
            end
          end
          if (mn > 127) mn = 127;
          r[e] = W'(sgn * mn);
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) msg_in1 <= layer_f(mode, tg, llr_q1, msg_out1);
  always_comb msg_in0 = layer_f(mode, tg, llr_q0, msg_out0);

  // Whole-decode reference: iterate the layer, decide, test H*x = 0.
  function automatic void model(input int md, input llr_t l, input int maxi,
                                output int k, output bit succ, output logic [N_V-1:0] hb);
    msg_t mo, mi;
    int   post;
    bit   par;
    for (int e = 0; e < E; e++) mo[e] = '0;
    k = 0; succ = 0; hb = '0;
    for (int it = 1; it <= maxi; it++) begin
      mi = layer_f(md, tg, l, mo);
      for (int v = 0; v < N_V; v++) begin
        post = int'(l[v]);
        for (int e = 0; e < E; e++) if (tg[e][0] == 8'(v)) post += int'(mi[e]);
        hb[v] = (post < 0);
      end
      succ = 1;
      for (int c = 0; c < N_C; c++) begin
        par = 0;
        for (int e = 0; e < E; e++)
          for (int v = 0; v < N_V; v++)
            if (tg[e][1] == 8'(c) && tg[e][0] == 8'(v)) par ^= hb[v];
        if (par) succ = 0;
      end
      k = it;
      if (succ) break;
      mo = mi;
    end
  endfunction

  task automatic snap(input bit s);
    if (s) begin
      o_busy = busy0; o_done = done0; o_succ = succ0; o_iter = int'(iter0);
      o_hard = hard0; o_llrq = llr_q0; o_mo = msg_out0;
    end else begin
      o_busy = busy1; o_done = done1; o_succ = succ1; o_iter = int'(iter1);
      o_hard = hard1; o_llrq = llr_q1; o_mo = msg_out1;
    end
  endtask

  task automatic rand_llr();
    int mag;
    for (int v = 0; v < N_V; v++) begin
      mag = int'($urandom_range(1, 12));
      llr[v] = W'(($urandom_range(0, 3) == 0) ? -mag : mag);
    end
  endtask

  // One decode on DUT s (0: LAYER_LAT=1, 1: LAYER_LAT=0). Optional start pulse while
  // busy, and optional back-to-back start with llr=nxt raised in the done cycle.
  task automatic decode(input bit s, input int md, input int pulse_at, input bit chain,
                        input llr_t nxt);
    int k, cnt, lat, maxi, exp_cyc;
    bit succ, held, ok;
    logic [N_V-1:0] hb;
    llr_t acc;
    lat  = s ? 0 : 1;
    maxi = s ? MAX0 : MAX1;
    mode = md;
    acc  = llr;
    model(md, acc, maxi, k, succ, hb);
    exp_cyc = 1 + k * (lat + 2);
    if (s) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    snap(s);
    checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL accept_busy dut%0d: busy=%b done=%b, want busy=1 done=0", s, o_busy, o_done);
    end
    ok = 1;
    for (int v = 0; v < N_V; v++) if (o_llrq[v] !== acc[v]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_llr_q dut%0d: llr_q differs from llr at accept", s); end
    ok = 1;
    for (int e = 0; e < E; e++) if (o_mo[e] !== '0) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL first_wait_msg_out dut%0d: msg_out not all zero", s); end
    held = 1;
    cnt  = 1;
    while (o_done !== 1'b1 && cnt < 600) begin
      for (int v = 0; v < N_V; v++) llr[v] = W'($urandom);
      if (cnt == pulse_at) begin
        if (s) start0 = 1'b1; else start1 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      cnt++;
      snap(s);
      if (o_done !== 1'b1 && o_busy !== 1'b1) held = 0;
      for (int v = 0; v < N_V; v++) if (o_llrq[v] !== acc[v]) held = 0;
    end
    checks++;
    if (o_done !== 1'b1) begin errors++; $display("FAIL done_timeout dut%0d: no done within %0d cycles, want one at %0d", s, cnt, exp_cyc); end
    checks++;
    if (cnt != exp_cyc) begin errors++; $display("FAIL done_cycle dut%0d: done at T+%0d, want T+%0d", s, cnt, exp_cyc); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL busy_at_done dut%0d: busy=%b, want 0", s, o_busy); end
    checks++;
    if (o_succ !== succ) begin errors++; $display("FAIL success dut%0d: got %b, want %b", s, o_succ, succ); end
    checks++;
    if (o_iter != k) begin errors++; $display("FAIL iter_used dut%0d: got %0d, want %0d", s, o_iter, k); end
    checks++;
    if (o_hard !== hb) begin errors++; $display("FAIL hard_bits dut%0d: got %b, want %b", s, o_hard, hb); end
    checks++;
    if (!held) begin errors++; $display("FAIL busy_llr_hold dut%0d: busy dropped or llr_q changed during decode", s); end
    if (chain) begin
      llr = nxt;
      if (s) start0 = 1'b1; else start1 = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok, seen;
    rst1 = 1'b1; rst0 = 1'b1; start1 = 1'b0; start0 = 1'b0; mode = M_CONST;
    for (int v = 0; v < N_V; v++) llr[v] = 8'sd20;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0; rst0 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      snap(s[0]);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_succ !== 1'b0 || o_iter != 0 || o_hard !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: busy=%b done=%b success=%b iter=%0d hard=%b, want all 0",
                 s, o_busy, o_done, o_succ, o_iter, o_hard);
      end
      ok = 1;
      for (int v = 0; v < N_V; v++) if (o_llrq[v] !== '0) ok = 0;
      for (int e = 0; e < E; e++) if (o_mo[e] !== '0) ok = 0;
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_arrays dut%0d: llr_q/msg_out not zero", s); end
    end
    // Abort a running decode with a two-cycle reset.
    mode = M_FORCE;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst1 = 1'b1;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0) seen = 1;
    end
    rst1 = 1'b0;
    snap(0);
    checks++;
    if (o_busy !== 1'b0 || o_succ !== 1'b0 || o_iter != 0 || o_hard !== '0) begin
      errors++;
      $display("FAIL midrun_reset dut0: busy=%b success=%b iter=%0d hard=%b, want all 0", o_busy, o_succ, o_iter, o_hard);
    end
    ok = 1;
    for (int v = 0; v < N_V; v++) if (o_llrq[v] !== '0) ok = 0;
    for (int e = 0; e < E; e++) if (o_mo[e] !== '0) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL midrun_reset_arrays dut0: llr_q/msg_out not zero"); end
    repeat (35) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0 || busy1 !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrun_reset_no_done dut0: done or busy seen after abort, want none"); end
  endtask

  task automatic test_first_iter_success();
    for (int v = 0; v < N_V; v++) llr[v] = 8'sd20;
    decode(1'b0, M_CONST, 0, 1'b0, llr);
    checks++;
    if (o_iter != 1 || o_succ !== 1'b1 || o_hard !== '0) begin
      errors++; $display("FAIL first_iter: iter=%0d success=%b hard=%b, want 1 1 0", o_iter, o_succ, o_hard);
    end
  endtask

  task automatic test_fail_at_limit();
    for (int v = 0; v < N_V; v++) llr[v] = 8'sd20;
    decode(1'b0, M_FORCE, 0, 1'b0, llr);
    checks++;
    if (o_iter != MAX1 || o_succ !== 1'b0 || o_hard[0] !== 1'b1) begin
      errors++; $display("FAIL fail_limit: iter=%0d success=%b hard0=%b, want %0d 0 1", o_iter, o_succ, o_hard[0], MAX1);
    end
  endtask

  task automatic test_minsum_random();
    for (int v = 0; v < N_V; v++) llr[v] = 8'sd6;
    llr[0] = -8'sd3;
    decode(1'b0, M_MINSUM, 0, 1'b0, llr);
    for (int i = 0; i < 8; i++) begin
      rand_llr();
      decode(1'(i % 2), M_MINSUM, 0, 1'b0, llr);
    end
  endtask

  task automatic test_back_to_back();
    llr_t nxt;
    for (int v = 0; v < N_V; v++) nxt[v] = W'(v + 3);
    nxt[2] = -8'sd2;
    rand_llr();
    decode(1'b0, M_MINSUM, 3, 1'b1, nxt);
    decode(1'b0, M_MINSUM, 2, 1'b0, llr);
  endtask

  task automatic test_zero_latency();
    bit seen;
    for (int v = 0; v < N_V; v++) llr[v] = 8'sd20;
    decode(1'b1, M_ONCE, 0, 1'b0, llr);
    checks++;
    if (o_iter != 2 || o_succ !== 1'b1) begin
      errors++; $display("FAIL zero_lat_iter2: iter=%0d success=%b, want 2 1", o_iter, o_succ);
    end
    // Reset landing on the CHECK cycle of the first iteration.
    mode = M_FORCE;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL rst_in_check: busy=%b done=%b, want 0 0", busy0, done0);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done0 !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_in_check_no_done: done seen after reset, want none"); end
  endtask

  initial begin
    int hv [0:11];
    hv = '{0, 2, 4, 6, 1, 2, 5, 6, 3, 4, 5, 6};
    for (int e = 0; e < 12; e++) begin
      tg[e][0] = 8'(hv[e]);
      tg[e][1] = 8'(e / 4);
    end
    tg[12][0] = 8'd0;   tg[12][1] = 8'd5;
    tg[13][0] = 8'd200; tg[13][1] = 8'd200;
    test_reset();
    test_first_iter_success();
    test_fail_at_limit();
    test_minsum_random();
    test_back_to_back();
    test_zero_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
